// File: rtl/prog_mem_loadable.sv
// Program memory with registered read, zeroed after reset, loaded by an LSB-first byte stream.
// Read latency 1 cycle; loader stalls on ld_valid_i low; reads are ignored while busy_o is high.
module prog_mem_loadable #(
    parameter int DATA_W = 35,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic [ADDR_W:0]   ld_count_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    output logic              busy_o,
    output logic              ld_done_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = (DATA_W + 7) / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [IDX_W+2:0]    shamt;
    logic [DATA_W-1:0]   lane_mask;
    logic [DATA_W-1:0]   lane_dat;
    logic [DATA_W-1:0]   word_asm;
    logic                rd_fire;

    // Current byte is merged combinationally so the final byte can be written on its own edge;
    // lanes above DATA_W fall off the shift and are discarded.
    always_comb begin
        shamt     = {idx_q, 3'b000};
        lane_mask = DATA_W'(8'hFF) << shamt;
        lane_dat  = DATA_W'(ld_byte_i) << shamt;
        word_asm  = (buf_q & ~lane_mask) | (lane_dat & lane_mask);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        done_d    = 1'b0;
        we        = 1'b0;
        waddr     = ptr_q;
        wdata     = '0;
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ld_start_i) begin
                    if (ld_count_i != '0) begin
                        wr_addr_d = ld_base_i;
                        cnt_d     = ld_count_i;
                        idx_d     = '0;
                        state_d   = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (ld_valid_i) begin
                    buf_d = word_asm;
                    if (idx_q == IDX_W'(NB - 1)) begin
                        we        = 1'b1;
                        waddr     = wr_addr_q;
                        wdata     = word_asm;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        idx_d     = '0;
                        cnt_d     = cnt_q - (ADDR_W + 1)'(1);
                        if (cnt_q == (ADDR_W + 1)'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            done_q    <= done_d;
        end
    end

    // Write port has no reset so it maps onto block RAM; reset still blocks a pending write.
    always_ff @(posedge clk_i) begin
        if (we && !rst_i) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_fire = rd_en_i && (state_q == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign ld_ready_o = (state_q == LOAD);
    assign busy_o     = (state_q != IDLE);
    assign ld_done_o  = done_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Directed bench for prog_mem_loadable: clear timing, byte loads, stalls, wrap, blocking and reset mid-load.
module tb_prog_mem_loadable;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [34:0] rd_data;
    logic        rd_valid;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic [8:0]  ld_count;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        busy;
    logic        ld_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [34:0] exp;
    } rvec_t;

    rvec_t tbl [10];

    prog_mem_loadable #(.DATA_W(35), .ADDR_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .ld_start_i (ld_start),
        .ld_base_i  (ld_base),
        .ld_count_i (ld_count),
        .ld_byte_i  (ld_byte),
        .ld_valid_i (ld_valid),
        .ld_ready_o (ld_ready),
        .busy_o     (busy),
        .ld_done_o  (ld_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [34:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({name, "_valid"}, 64'(rd_valid), 64'd1);
        chk({name, "_data"}, 64'(rd_data), 64'(exp));
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] cnt);
        ld_start = 1'b1;
        ld_base  = base;
        ld_count = cnt;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ld_byte  = b;
        ld_valid = 1'b1;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ld_ready) chk("ld_ready_timeout", 64'(ld_ready), 64'd1);
        tick();
        ld_valid = 1'b0;
        ld_byte  = 8'hA5;
    endtask

    task automatic send_stall(input logic [7:0] b, input int gaps);
        ld_valid = 1'b0;
        ld_byte  = 8'h5A;
        for (int i = 0; i < gaps; i++) begin
            tick();
            chk("stall_ready", 64'(ld_ready), 64'd1);
        end
        send_byte(b);
    endtask

    // Counts cycles until busy falls, also recording whether ld_done ever pulsed.
    task automatic wait_clear(output int n, output bit done_seen);
        n         = 0;
        done_seen = 1'b0;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (ld_done) done_seen = 1'b1;
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [7:0] s0 [5];

        rst = 1'b1; rd_en = 1'b0; rd_addr = '0; ld_start = 1'b0; ld_base = '0;
        ld_count = '0; ld_byte = '0; ld_valid = 1'b0;

        repeat (300) tick();
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_ld_done", 64'(ld_done), 64'd0);

        rst = 1'b0;
        wait_clear(n, seen);
        chk("clear_cycles", 64'(n), 64'd256);
        chk("clear_no_done", 64'(seen), 64'd0);

        for (int a = 0; a < 256; a++) rd(8'(a), 35'd0, "clear_zero");
        tick();
        chk("idle_rd_valid_low", 64'(rd_valid), 64'd0);
        chk("idle_rd_data_hold", 64'(rd_data), 64'd0);

        // Two-word load, read in the ld_done cycle
        start_load(8'h10, 9'd2);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_ready", 64'(ld_ready), 64'd1);
        s0 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 5; i++) send_byte(s0[i]);
        chk("mid_load_no_done", 64'(ld_done), 64'd0);
        s0 = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'h07};
        for (int i = 0; i < 5; i++) send_byte(s0[i]);
        chk("load2_done", 64'(ld_done), 64'd1);
        chk("load2_busy_low", 64'(busy), 64'd0);
        chk("load2_ready_low", 64'(ld_ready), 64'd0);
        rd(8'h11, 35'h7_CCDD_EEFF, "done_cycle_read");
        chk("load2_done_once", 64'(ld_done), 64'd0);

        // One word with stalls; garbage on ld_byte while ld_valid is low
        start_load(8'h20, 9'd1);
        send_stall(8'h11, 0);
        send_stall(8'h22, 2);
        send_stall(8'h33, 2);
        send_stall(8'h44, 1);
        send_stall(8'hFF, 3);
        chk("stall_done", 64'(ld_done), 64'd1);

        // Wrapping load
        start_load(8'hFF, 9'd3);
        s0 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01};
        for (int i = 0; i < 5; i++) send_byte(s0[i]);
        s0 = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h02};
        for (int i = 0; i < 5; i++) send_byte(s0[i]);
        s0 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h03};
        for (int i = 0; i < 5; i++) send_byte(s0[i]);
        chk("wrap_done", 64'(ld_done), 64'd1);
        tick();

        tbl[0] = '{8'h10, 35'h4_0302_0100};
        tbl[1] = '{8'h11, 35'h7_CCDD_EEFF};
        tbl[2] = '{8'h20, 35'h7_4433_2211};
        tbl[3] = '{8'hFF, 35'h1_A4A3_A2A1};
        tbl[4] = '{8'h00, 35'h2_B4B3_B2B1};
        tbl[5] = '{8'h01, 35'h3_C4C3_C2C1};
        tbl[6] = '{8'hFE, 35'h0};
        tbl[7] = '{8'h02, 35'h0};
        tbl[8] = '{8'h12, 35'h0};
        tbl[9] = '{8'h0F, 35'h0};
        for (int i = 0; i < 10; i++) rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));

        // Read accepted alongside ld_start, then rd_en/ld_start ignored in LOAD
        rd_en = 1'b1; rd_addr = 8'h20;
        start_load(8'h30, 9'd1);
        chk("rd_with_start_valid", 64'(rd_valid), 64'd1);
        chk("rd_with_start_data", 64'(rd_data), 64'h7_4433_2211);
        chk("rd_with_start_busy", 64'(busy), 64'd1);
        rd_addr = 8'h10; ld_start = 1'b1; ld_base = 8'h40; ld_count = 9'd5;
        repeat (3) tick();
        chk("blocked_rd_valid", 64'(rd_valid), 64'd0);
        chk("blocked_rd_data", 64'(rd_data), 64'h7_4433_2211);
        rd_en = 1'b0; ld_start = 1'b0;
        s0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 5; i++) send_byte(s0[i]);
        chk("ignored_start_done", 64'(ld_done), 64'd1);
        tick();
        chk("ignored_start_idle", 64'(busy), 64'd0);
        rd(8'h30, 35'h5_0403_0201, "load30");
        rd(8'h40, 35'h0, "no_load40");

        // Zero-count load
        start_load(8'h50, 9'd0);
        chk("zero_cnt_done", 64'(ld_done), 64'd1);
        chk("zero_cnt_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_cnt_done_once", 64'(ld_done), 64'd0);
        chk("zero_cnt_still_idle", 64'(busy), 64'd0);

        // Reset after three bytes of a word
        start_load(8'h50, 9'd1);
        s0 = '{8'h99, 8'h88, 8'h77, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) send_byte(s0[i]);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(busy), 64'd1);
        chk("mid_rst_ready", 64'(ld_ready), 64'd0);
        chk("mid_rst_done", 64'(ld_done), 64'd0);
        rst = 1'b0;
        wait_clear(n, seen);
        chk("reclear_cycles", 64'(n), 64'd256);
        chk("reclear_no_done", 64'(seen), 64'd0);
        rd(8'h10, 35'h0, "reclear_10");
        rd(8'h50, 35'h0, "reclear_50");
        rd(8'hFF, 35'h0, "reclear_ff");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_mem_loadable.md
Name: prog_mem_loadable

Overview:
Parametrised synchronous program memory for the CPU. It replaces the fixed combinational instruction table with a registered-read memory whose contents are zero (NOP) after reset and are loaded at run time through a byte-stream loader with a valid/ready handshake. It sits between the program counter (read port) and a host/debug byte source (loader port). The `busy` output holds the CPU off while the memory is being cleared or loaded.

Parameters:
DATA_W, 35, instruction word width in bits (1..64)
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words (localparam)
NB (localparam), ceil(DATA_W/8), bytes per word on loader port (5 at default)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data updated by a read accepted in the previous cycle
ld_start  in  1  begin a load (sampled in IDLE only)
ld_base  in  ADDR_W  first word address of load, latched on ld_start
ld_count  in  ADDR_W+1  number of words to load, latched on ld_start (0..DEPTH)
ld_byte  in  8  loader data byte
ld_valid  in  1  ld_byte valid
ld_ready  out  1  loader accepts byte this cycle
busy  out  1  memory in CLEAR or LOAD; reads ignored
ld_done  out  1  one-cycle pulse: load finished

Behaviour:
- Reset (rst=1 at edge): rd_data=0, rd_valid=0, ld_ready=0, ld_done=0, busy=1, state=CLEAR, clear pointer=0, byte index=0. Reset wins over every other input, including mid-CLEAR and mid-LOAD.
- States: CLEAR, IDLE, LOAD.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle; ptr increments.
  - After writing DEPTH-1, next state is IDLE.
  - Takes exactly DEPTH cycles after reset deasserts; busy=1 throughout.
- IDLE: busy=0, ld_ready=0.
  - Read: if rd_en at edge N, then at edge N rd_data<=mem[rd_addr] and rd_valid<=1. 1-cycle latency.
  - If rd_en=0, rd_valid<=0 and rd_data holds its value.
  - ld_start=1 and ld_count!=0: latch base/count, wr_addr<=ld_base, byte index<=0, go to LOAD. busy=1 from the next cycle.
  - ld_start=1 and ld_count==0: no state change; ld_done pulses the next cycle.
  - rd_en and ld_start in the same cycle: the read completes normally and LOAD is entered.
- LOAD: busy=1, ld_ready=1.
  - rd_en is ignored: rd_valid<=0 and rd_data holds.
  - ld_start is ignored.
  - Handshake: a byte transfers on an edge where ld_valid&&ld_ready. ld_valid=0 stalls indefinitely with no timeout.
  - Byte k of a word (k=0..NB-1, LSB first) fills bits [8k+7:8k]. Bits at or above DATA_W are discarded.
  - On the edge accepting byte NB-1: mem[wr_addr]<=assembled word (final byte included combinationally); wr_addr<=wr_addr+1, wrapping modulo DEPTH; byte index<=0; remaining count decrements.
  - When the last word is written: next state IDLE, ld_done=1 for exactly the following cycle, busy=0 in that same cycle, ld_ready=0.
  - A read of a just-written address, issued in the ld_done cycle, returns the new word.
- Reset during LOAD: partial words are discarded, the FSM re-enters CLEAR, and all memory is zeroed again.
- ld_count=DEPTH with nonzero base wraps and overwrites every word exactly once.
- Memory inference: single write port and single registered read port (block RAM compatible). Read and write are never simultaneous, because reads are blocked while busy.

Test Plan:
- Reset, hold 300 cycles -> busy=1 for exactly 256 cycles after rst falls. Then read every address 0..255 -> rd_data=0, rd_valid=1 one cycle after each rd_en.
- ld_start, base=0x10, count=2, bytes 00,01,02,03,04 then FF,EE,DD,CC,07 -> mem[0x10]=35'h4_0302_0100, mem[0x11]=35'h7_CCDD_EEFF. ld_done pulses once; the read in the ld_done cycle returns the new word.
- Load of 1 word with ld_valid toggling 1,0,0,1,... and last byte 0xFF -> stalls are honoured, no byte is lost, upper 5 bits are dropped, and bits [34:32]=3'b111.
- base=0xFF, count=3 -> writes land at 0xFF, 0x00, 0x01 (wrap); 0xFE and 0x02 stay 0.
- rd_en and ld_start during LOAD -> rd_valid stays 0 and rd_data is unchanged; the second ld_start has no effect. ld_count=0 in IDLE -> ld_done pulse next cycle, busy stays 0.
- rst asserted after 3 bytes of a word in LOAD -> CLEAR runs, a previously loaded word at 0x10 reads 0 afterwards, and ld_done never pulses.
